// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the digital clock blocks: FSM state encoding,
// BCD field limits, and a BCD digit helper.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [7:0] HOUR_MAX    = 8'h23;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam int         SEC_PER_MIN = 60;

  // Both nibbles of a packed BCD byte are decimal digits.
  function automatic logic bcd_byte_ok(logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Keyboard <-> alarm controller link.
//   set_data   16  BCD HHMM committed by the keyboard
//   set_vld     1  1-cycle commit strobe
//   edit_req    1  1-cycle request to preload the keyboard
//   alarm_time 16  stored alarm, BCD HHMM (keyboard data_in)
//   load        1  1-cycle preload strobe
//   set_err     1  1-cycle: committed value rejected
// master = keyboard side, slave = alarm controller side.
interface alarm_ctrl_if;
  logic [15:0] set_data;
  logic        set_vld;
  logic        edit_req;
  logic [15:0] alarm_time;
  logic        load;
  logic        set_err;

  modport master (
    output set_data, set_vld, edit_req,
    input  alarm_time, load, set_err
  );

  modport slave (
    input  set_data, set_vld, edit_req,
    output alarm_time, load, set_err
  );
endinterface

// File: rtl/alarm_ctrl_bcd_hhmm_check.sv
// Combinational BCD HHMM validator: every nibble a decimal digit,
// HH <= 23, MM <= 59. Shared by the keyboard and time-set logic.
//   hhmm   in  16  BCD HHMM
//   valid  out  1  1 = legal time of day
module bcd_hhmm_check
  import alarm_ctrl_pkg::*;
(
  input  logic [15:0] hhmm,
  output logic        valid
);
  logic [7:0] hh, mm;

  assign hh = hhmm[15:8];
  assign mm = hhmm[7:0];

  // Once both nibbles are decimal, a plain binary compare orders BCD bytes.
  assign valid = bcd_byte_ok(hh) && bcd_byte_ok(mm) &&
                 (hh <= HOUR_MAX) && (mm <= MIN_MAX);
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the alarm time committed by the keyboard, matches
// it against the running clock, drives the buzzer for RING_SEC seconds and
// hands the stored time back to the keyboard on an edit request.
// Optional feature macro: ALARM_SNOOZE_EN (stop during ringing snoozes for
// SNOOZE_MIN minutes instead of disarming until the next match).
//   clk, rst_n   clock, asynchronous active-low reset
//   kb           keyboard link (alarm_ctrl_if.slave)
//   cur_time 16  running clock, BCD HHMM
//   cur_sec   8  running clock seconds, BCD
//   sec_tick  1  1-cycle pulse per second
//   alarm_on  1  alarm enable switch (level)
//   stop_flag 1  filtered stop key (1-cycle)
//   ring      1  buzzer enable
//   state     2  FSM state (debug)
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int          RING_SEC   = 60,
`ifdef ALARM_SNOOZE_EN
  parameter int          SNOOZE_MIN = 5,
`endif
  parameter logic [15:0] ALARM_RST  = 16'h0700
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_ctrl_if.slave  kb,
  input  logic [15:0]  cur_time,
  input  logic [7:0]   cur_sec,
  input  logic         sec_tick,
  input  logic         alarm_on,
  input  logic         stop_flag,
  output logic         ring,
  output logic [1:0]   state
);

  localparam logic [7:0] RING_END = 8'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNZ_END  = 10'(SNOOZE_MIN * SEC_PER_MIN);
`endif

  logic        data_ok, set_ok;
  logic [15:0] alarm_q;
  logic        load_q, set_err_q;
  logic        match, match_d, trig;
  state_t      st;
  logic [7:0]  ring_cnt;
`ifdef ALARM_SNOOZE_EN
  logic [9:0]  snz_cnt;
`endif

  bcd_hhmm_check u_chk (
    .hhmm  (kb.set_data),
    .valid (data_ok)
  );

  assign set_ok = kb.set_vld & data_ok;

  assign kb.alarm_time = alarm_q;
  assign kb.load       = load_q;
  assign kb.set_err    = set_err_q;
  assign state         = st;

  // Held for the whole matching second, so only the rising edge triggers.
  assign match = alarm_on && (cur_sec == 8'h00) && (cur_time == alarm_q);
  assign trig  = match & ~match_d;

  // Stored alarm and keyboard strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q   <= ALARM_RST;
      load_q    <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      load_q    <= kb.edit_req;
      set_err_q <= kb.set_vld & ~data_ok;
      if (set_ok) alarm_q <= kb.set_data;
    end
  end

  // Alarm FSM. Priority: switch off, then an accepted set (which also masks
  // a same-cycle trigger), then per-state behaviour. Within RINGING, stop
  // outranks the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      ring     <= 1'b0;
      ring_cnt <= '0;
      match_d  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      match_d <= match;
      if (!alarm_on) begin
        st       <= IDLE;
        ring     <= 1'b0;
        ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
        snz_cnt  <= '0;
`endif
      end else if (set_ok) begin
        st       <= ARMED;
        ring     <= 1'b0;
        ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
        snz_cnt  <= '0;
`endif
      end else begin
        case (st)
          IDLE: st <= ARMED;
          ARMED: begin
            if (trig) begin
              st       <= RINGING;
              ring     <= 1'b1;
              ring_cnt <= '0;
            end
          end
          RINGING: begin
            if (stop_flag) begin
              ring     <= 1'b0;
              ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
              snz_cnt  <= '0;
              st       <= SNOOZE;
`else
              st       <= ARMED;
`endif
            end else if (sec_tick) begin
              if (ring_cnt + 8'd1 == RING_END) begin
                st       <= ARMED;
                ring     <= 1'b0;
                ring_cnt <= '0;
              end else begin
                ring_cnt <= ring_cnt + 8'd1;
              end
            end
          end
`ifdef ALARM_SNOOZE_EN
          SNOOZE: begin
            if (sec_tick) begin
              if (snz_cnt + 10'd1 == SNZ_END) begin
                st       <= RINGING;
                ring     <= 1'b1;
                ring_cnt <= '0;
                snz_cnt  <= '0;
              end else begin
                snz_cnt <= snz_cnt + 10'd1;
              end
            end
          end
`endif
          default: begin
            st   <= IDLE;
            ring <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

  typedef enum logic [2:0] {EV_AT, EV_ERR, EV_LOAD, EV_RING, EV_SNAP} ev_t;
  typedef struct {
    ev_t         kind;
    logic [20:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cur_time;
  logic [7:0]  cur_sec;
  logic        sec_tick, alarm_on, stop_flag;
  logic        ring;
  logic [1:0]  state;

  alarm_ctrl_if kb();

  alarm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kb        (kb),
    .cur_time  (cur_time),
    .cur_sec   (cur_sec),
    .sec_tick  (sec_tick),
    .alarm_on  (alarm_on),
    .stop_flag (stop_flag),
    .ring      (ring),
    .state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  logic snap_req = 1'b0;
  logic mon_en   = 1'b0;
  logic done     = 1'b0;

  // ---------------- monitor / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] prev_at   = 16'h0700;
  logic        prev_ring = 1'b0;
  exp_t        e;

  task automatic got(ev_t k, logic [20:0] d);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s: got data=%h at cyc %0d, required no event", k.name(), d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: got %s data=%h cyc %0d, required %s data=%h cyc %0d",
                 e.kind.name(), k.name(), d, cyc, e.kind.name(), e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (kb.alarm_time !== prev_at) begin
        got(EV_AT, {5'd0, kb.alarm_time});
        prev_at = kb.alarm_time;
      end
      if (kb.set_err !== 1'b0) got(EV_ERR, {5'd0, kb.alarm_time});
      if (kb.load !== 1'b0)    got(EV_LOAD, {5'd0, kb.alarm_time});
      if (ring !== prev_ring) begin
        got(EV_RING, {18'd0, ring, state});
        prev_ring = ring;
      end
      if (snap_req) got(EV_SNAP, {kb.alarm_time, ring, kb.load, kb.set_err, state});
    end
    if (done) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing %s: got nothing, required data=%h at cyc %0d", e.kind.name(), e.data, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] exp_at = 16'h0700;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(ev_t k, logic [20:0] d, int dc);
    sb.push_back('{k, d, cyc + dc});
  endtask

  task automatic expect_ring(logic r, logic [1:0] st, int dc);
    expect_ev(EV_RING, {18'd0, r, st}, dc);
  endtask

  task automatic snap(logic [15:0] at, logic r, logic [1:0] st);
    expect_ev(EV_SNAP, {at, r, 1'b0, 1'b0, st}, 0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      step();
    end
  endtask

  task automatic retrig();
    cur_sec = 8'h00;
    expect_ring(1'b1, S_RING, 1);
    step();
    cur_sec = 8'h01;
  endtask

  logic [15:0] set_tab [9] = '{16'h0630, 16'h2460, 16'h1A05, 16'h2400, 16'h0960,
                               16'h195A, 16'h2359, 16'h0000, 16'h0630};
  logic        ok_tab  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    kb.set_data = 16'h0000; kb.set_vld = 1'b0; kb.edit_req = 1'b0;
    cur_time = 16'h0000; cur_sec = 8'h01;
    sec_tick = 1'b0; alarm_on = 1'b0; stop_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    snap(16'h0700, 1'b0, S_IDLE);

    // set path: valid values store, invalid ones pulse set_err
    for (int i = 0; i < 9; i++) begin
      kb.set_data = set_tab[i];
      kb.set_vld  = 1'b1;
      if (ok_tab[i]) begin
        exp_at = set_tab[i];
        expect_ev(EV_AT, {5'd0, exp_at}, 1);
      end else begin
        expect_ev(EV_ERR, {5'd0, exp_at}, 1);
      end
      step();
    end
    kb.set_vld = 1'b0;
    step();
    snap(16'h0630, 1'b0, S_IDLE);

    // preload
    kb.edit_req = 1'b1;
    expect_ev(EV_LOAD, {5'd0, 16'h0630}, 1);
    step();
    kb.edit_req = 1'b0;
    step();
    step();

    // arm, match on the minute edge, full ring duration
    alarm_on = 1'b1;
    step();
    snap(16'h0630, 1'b0, S_ARMED);
    cur_time = 16'h0629; cur_sec = 8'h00;
    step();
    cur_time = 16'h0630;
    expect_ring(1'b1, S_RING, 1);
    step();
    cur_sec = 8'h01;
    ticks(59);
    sec_tick = 1'b1;
    expect_ring(1'b0, S_ARMED, 1);
    step();
    sec_tick = 1'b0;
    step();

    // stop coinciding with the ring timeout: stop wins
    retrig();
    ticks(59);
    sec_tick = 1'b1; stop_flag = 1'b1;
`ifdef ALARM_SNOOZE_EN
    expect_ring(1'b0, S_SNZ, 1);
`else
    expect_ring(1'b0, S_ARMED, 1);
`endif
    step();
    sec_tick = 1'b0; stop_flag = 1'b0;
    step();

    // snooze length (re-ring only with the snooze build)
`ifdef ALARM_SNOOZE_EN
    ticks(299);
    sec_tick = 1'b1;
    expect_ring(1'b1, S_RING, 1);
    step();
    sec_tick = 1'b0;
    step();
`else
    ticks(300);
    retrig();
    step();
`endif

    // set while ringing: back to ARMED, ring off
    kb.set_data = 16'h0630; kb.set_vld = 1'b1;
    expect_ring(1'b0, S_ARMED, 1);
    step();
    kb.set_vld = 1'b0;
    step();

    // set in the same cycle as a trigger: no ring
    cur_sec = 8'h00; kb.set_vld = 1'b1;
    step();
    kb.set_vld = 1'b0; cur_sec = 8'h01;
    step();

    // stop outside RINGING is ignored
    stop_flag = 1'b1;
    step();
    stop_flag = 1'b0;
    snap(16'h0630, 1'b0, S_ARMED);

    // alarm switch off while ringing
    retrig();
    ticks(3);
    alarm_on = 1'b0;
    expect_ring(1'b0, S_IDLE, 1);
    step();
    alarm_on = 1'b1;
    step();

    // asynchronous reset while ringing, released before the next edge
    retrig();
    ticks(2);
    expect_ev(EV_AT, {5'd0, 16'h0700}, 0);
    expect_ring(1'b0, S_IDLE, 0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    snap(16'h0700, 1'b0, S_ARMED);

    repeat (3) step();
    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL summary_timeout: monitor did not finish, required finish within 20 cycles");
    $fatal(1, "monitor did not finish");
  end

endmodule
